// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester round-robin front end for a single shared ALU. One
//   operation is in flight at a time: IDLE grants and accepts, BUSY drives
//   the ALU until it signals done or the timeout expires, and RESP presents
//   the result to the requester that was granted.
//
//   Handshakes are strict valid/ready. A transfer happens on a rising edge
//   where both valid and ready are high. A requester may drop valid before
//   it is granted, which withdraws the request. A response holds valid,
//   result and err stable until ready is sampled high.
//
// Ports
//   clk, reset_n                    clock, asynchronous active-low reset
//   reqN_valid/ready, reqN_a/b/op   request channel N (op: 1 add, 2 and,
//                                   3 xor, 4 mul; other codes -> err)
//   rspN_valid/ready, rspN_result/err  response channel N
//   alu_start, alu_a/b/op           shared ALU command (zero when idle)
//   alu_done, alu_result            shared ALU completion
//   dbg_state                       current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module alu_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        alu_start,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // The counter holds the number of BUSY cycles already completed, so the
  // TIMEOUT-th BUSY cycle is the one where it equals TIMEOUT-1.
  localparam logic [7:0] LAST_BUSY = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  a_q, b_q;
  logic [2:0]  op_q;
  logic        idx_q;
  logic        last_q;
  logic [7:0]  cnt_q;
  logic [15:0] res_q;
  logic        err_q;

  logic        any_valid;
  logic        grant;
  logic        accept;
  logic [2:0]  sel_op;
  logic        op_legal;
  logic        rsp_fire;
  logic        timeout_hit;

  assign any_valid = req0_valid | req1_valid;

  // With both valid, the one not granted last wins; otherwise whichever is
  // valid. The value is don't-care when neither is valid (accept is low).
  assign grant       = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign accept      = (state == IDLE) && any_valid;
  assign sel_op      = grant ? req1_op : req0_op;
  assign op_legal    = (sel_op >= 3'd1) && (sel_op <= 3'd4);
  assign rsp_fire    = (state == RESP) && (idx_q ? rsp1_ready : rsp0_ready);
  assign timeout_hit = (cnt_q == LAST_BUSY);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = op_legal ? BUSY : RESP;
      BUSY: if (alu_done || timeout_hit) state_nxt = RESP;
      RESP: if (rsp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered operation, round-robin pointer, counter and response
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      op_q   <= 3'd0;
      idx_q  <= 1'b0;
      last_q <= 1'b1;   // pretend requester 1 went last so requester 0 leads
      cnt_q  <= 8'h00;
      res_q  <= 16'h0000;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= grant ? req1_a : req0_a;
            b_q    <= grant ? req1_b : req0_b;
            op_q   <= sel_op;
            idx_q  <= grant;
            last_q <= grant;
            cnt_q  <= 8'h00;
            res_q  <= 16'h0000;
            err_q  <= ~op_legal;
          end
        end
        BUSY: begin
          if (alu_done) begin
            res_q <= alu_result;
            err_q <= 1'b0;
          end else if (timeout_hit) begin
            res_q <= 16'h0000;
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs. The ready outputs are gated with reset_n so they stay low
  // while reset is asserted even if a requester is already valid.
  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    alu_start   = 1'b0;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_op      = 3'd0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    rsp0_result = 16'h0000;
    rsp1_result = 16'h0000;
    rsp0_err    = 1'b0;
    rsp1_err    = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = reset_n && any_valid && !grant;
        req1_ready = reset_n && any_valid &&  grant;
      end
      BUSY: begin
        alu_start = 1'b1;
        alu_a     = a_q;
        alu_b     = b_q;
        alu_op    = op_q;
      end
      RESP: begin
        if (idx_q) begin
          rsp1_valid  = 1'b1;
          rsp1_result = res_q;
          rsp1_err    = err_q;
        end else begin
          rsp0_valid  = 1'b1;
          rsp0_result = res_q;
          rsp0_err    = err_q;
        end
      end
      default: ;
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Directed scenarios followed by randomized traffic. A reference model of
//   the arbiter's externally visible behaviour (which requester wins, how
//   many cycles the ALU is driven, when the response appears) runs on the
//   falling edge, plays the shared ALU, and pushes expected responses into a
//   queue that is popped whenever the DUT completes a response handshake.
module tb_alu_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0]  req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp0_err;
  logic        rsp1_valid, rsp1_ready, rsp1_err;
  logic [15:0] rsp0_result, rsp1_result;
  logic        alu_start, alu_done;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic [1:0]  dbg_state;

  alu_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_done(alu_done), .alu_result(alu_result),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  // {idx, err, result}
  logic [17:0] exp_q[$];
  int          grant_log[$];
  int          acc_cnt      = 0;
  int          forced_delay = -1;
  bit          rand_mode    = 1'b0;

  // reference model state: 0 waiting for a grant, 1 ALU driven, 2 response
  int          m_phase = 0;
  int          m_bc    = 0;
  int          m_d     = 0;
  logic        m_last  = 1'b1;
  logic        m_idx   = 1'b0;
  logic [7:0]  m_a     = 8'h00;
  logic [7:0]  m_b     = 8'h00;
  logic [2:0]  m_op    = 3'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return {8'h00, a & b};
      3'd3:    return {8'h00, a ^ b};
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  // Expected {err, result}: bad opcode or an ALU slower than TIMEOUT -> error
  function automatic logic [16:0] ref_rsp(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input int d);
    if (op < 3'd1 || op > 3'd4) return {1'b1, 16'h0000};
    if (d > TIMEOUT)            return {1'b1, 16'h0000};
    return {1'b0, alu_calc(op, a, b)};
  endfunction

  // ---------------- model / ALU / monitor ----------------
  initial begin
    logic        g;
    logic [17:0] e;
    alu_done   = 1'b0;
    alu_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_req_ready", {req0_ready, req1_ready}, 0);
        chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
        chk("rst_rsp_data", {rsp0_err, rsp1_err, rsp0_result, rsp1_result}, 0);
        chk("rst_alu", {alu_start, alu_a, alu_b, alu_op}, 0);
        m_phase = 0;
        m_last  = 1'b1;
        exp_q.delete();
        alu_done   = 1'b0;
        alu_result = 16'h0000;
      end else begin
        // ALU command side
        chk("alu_start", alu_start, (m_phase == 1));
        if (m_phase == 1) chk("alu_operands", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
        else              chk("alu_idle_zero", {alu_a, alu_b, alu_op}, 0);
        // response side
        chk("rsp0_valid", rsp0_valid, (m_phase == 2 && m_idx == 1'b0));
        chk("rsp1_valid", rsp1_valid, (m_phase == 2 && m_idx == 1'b1));
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_unexpected: response with empty queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            if (rsp1_valid) chk("rsp1_data", {1'b1, rsp1_err, rsp1_result}, e);
            else            chk("rsp0_data", {1'b0, rsp0_err, rsp0_result}, e);
          end
        end
        // request side
        chk("ready_onehot", req0_ready & req1_ready, 0);
        g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
        if (m_phase == 0 && (req0_valid || req1_valid))
          chk("grant", {req1_ready, req0_ready}, g ? 2'b10 : 2'b01);
        else
          chk("no_grant", {req1_ready, req0_ready}, 0);

        // advance the model and play the ALU for the coming edge
        alu_done   = 1'($urandom_range(0, 1));   // outside BUSY it must be ignored
        alu_result = 16'($urandom);
        case (m_phase)
          0: if (req0_valid || req1_valid) begin
            m_idx  = g;
            m_a    = g ? req1_a  : req0_a;
            m_b    = g ? req1_b  : req0_b;
            m_op   = g ? req1_op : req0_op;
            m_d    = (forced_delay >= 0) ? forced_delay : $urandom_range(1, TIMEOUT + 3);
            m_last = g;
            m_bc   = 0;
            exp_q.push_back({m_idx, ref_rsp(m_op, m_a, m_b, m_d)});
            grant_log.push_back(int'(g));
            acc_cnt++;
            m_phase = (m_op >= 3'd1 && m_op <= 3'd4) ? 1 : 2;
          end
          1: begin
            m_bc++;
            alu_done   = (m_bc == m_d);
            alu_result = alu_calc(alu_op, alu_a, alu_b);
            if (m_bc == m_d || m_bc == TIMEOUT) m_phase = 2;
          end
          default: if (m_idx ? rsp1_ready : rsp0_ready) m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- random driver ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_mode) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req1_valid = ($urandom_range(0, 3) != 0);
        req0_a  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        req0_b  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        req1_a  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        req1_b  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
        req0_op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
        req1_op = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
        rsp0_ready = ($urandom_range(0, 2) != 0);
        rsp1_ready = ($urandom_range(0, 2) != 0);
      end
    end
  end

  // ---------------- directed driver tasks ----------------
  task automatic wait_idle();
    int i;
    for (i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (m_phase == 0 && exp_q.size() == 0) break;
    end
    if (i == 60) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: transaction did not complete at %0t", $time);
    end
  endtask

  task automatic wait_accepts(input int n);
    int i;
    int start = acc_cnt;
    for (i = 0; i < 200 && acc_cnt < start + n; i++) begin
      @(posedge clk); #1;
    end
    if (acc_cnt < start + n) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got %0d of %0d grants", acc_cnt - start, n);
    end
  endtask

  task automatic issue(input logic idx, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input int d, input bit wait_rsp);
    forced_delay = d;
    if (idx) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    wait_accepts(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (wait_rsp) wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int pat[4];
    pat = '{0, 1, 0, 1};
    reset_n    = 1'b0;
    req0_valid = 1'b1;   // valid during reset must not produce ready
    req1_valid = 1'b1;
    req0_a = 8'h00; req0_b = 8'h00; req0_op = 3'd0;
    req1_a = 8'h00; req1_b = 8'h00; req1_op = 3'd0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    issue(1'b0, 8'd5, 8'd7, 3'd1, 1, 1'b1);       // add, done after one cycle
    issue(1'b1, 8'hFF, 8'hFF, 3'd4, 3, 1'b1);     // mul, done after three

    // both continuously valid: alternate starting with requester 0
    forced_delay = 2;
    grant_log.delete();
    req0_a = 8'd1; req0_b = 8'd2; req0_op = 3'd1; req0_valid = 1'b1;
    req1_a = 8'd3; req1_b = 8'd4; req1_op = 3'd3; req1_valid = 1'b1;
    wait_accepts(4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    chk("rr_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_order", grant_log[i], pat[i]);

    issue(1'b0, 8'h12, 8'h34, 3'd6, 0, 1'b1);     // illegal opcode
    issue(1'b0, 8'h00, 8'h00, 3'd0, 0, 1'b1);     // opcode 0
    issue(1'b1, 8'd3, 8'd4, 3'd1, 255, 1'b1);     // ALU never finishes
    issue(1'b0, 8'hA5, 8'h3C, 3'd2, TIMEOUT, 1'b1);      // done on the last cycle
    issue(1'b0, 8'hA5, 8'h3C, 3'd3, TIMEOUT + 1, 1'b1);  // one cycle too late

    // reset in the middle of a mul
    issue(1'b1, 8'hFF, 8'hFF, 3'd4, 255, 1'b0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_alu_start", alu_start, 0);
    chk("async_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    forced_delay = 1;
    grant_log.delete();
    req0_a = 8'd9; req0_b = 8'd9; req0_op = 3'd1; req0_valid = 1'b1;
    req1_a = 8'd7; req1_b = 8'd7; req1_op = 3'd1; req1_valid = 1'b1;
    wait_accepts(1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (grant_log.size() > 0) chk("post_reset_grant", grant_log[0], 0);
    else chk("post_reset_grant_seen", grant_log.size(), 1);
    wait_idle();

    // randomized traffic
    forced_delay = -1;
    rand_mode = 1'b1;
    repeat (3000) @(posedge clk);
    rand_mode = 1'b0;
    @(posedge clk); #2;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    wait_idle();
    chk("drained", exp_q.size(), 0);
    chk("traffic_seen", (acc_cnt > 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
